// File: rtl/key_toggle_gen.sv
// Debounced active-low push-button to one-cycle toggle requests, with auto-repeat.
// Ports: i_clk, i_rst_n (sync, active-low), i_key (raw, active-low) -> o_t, o_key_level.
module key_toggle_gen #(
  parameter int CNT_W         = 24,
  parameter int DB_CYCLES     = 8,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_t,
  output logic o_key_level
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit               RPT_EN    = (REPEAT_CYCLES != 0);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_done;
  logic             r_t;
  logic             r_level;

  state_t           w_nxt;
  logic [CNT_W-1:0] w_db_nxt;
  logic [CNT_W-1:0] w_rpt_nxt;
  logic             w_done_nxt;
  logic             w_t_nxt;
  logic             w_key_s;
  logic [CNT_W-1:0] w_db_inc;
  logic [CNT_W-1:0] w_rpt_inc;

  assign w_key_s = r_sync2;

  // Saturating increments: counters never wrap.
  assign w_db_inc  = (r_db_cnt == CNT_MAX) ? r_db_cnt
                   : r_db_cnt + CNT_W'(1);
  assign w_rpt_inc = (r_rpt_cnt == CNT_MAX) ? r_rpt_cnt
                   : r_rpt_cnt + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_db_cnt   <= '0;
      r_rpt_cnt  <= '0;
      r_rpt_done <= 1'b0;
      r_t        <= 1'b0;
      r_level    <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_db_cnt   <= w_db_nxt;
      r_rpt_cnt  <= w_rpt_nxt;
      r_rpt_done <= w_done_nxt;
      r_t        <= w_t_nxt;
      r_level    <= (w_nxt == PRESSED) ||
                    (w_nxt == RELEASE_DB);
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_db_nxt   = r_db_cnt;
    w_rpt_nxt  = '0;
    w_done_nxt = 1'b0;
    w_t_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_db_nxt = '0;
        if (!w_key_s) begin
          w_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (w_key_s) begin
          w_nxt    = IDLE;
          w_db_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_nxt    = PRESSED;
          w_db_nxt = '0;
          w_t_nxt  = 1'b1;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end
      PRESSED: begin
        if (w_key_s) begin
          w_nxt    = RELEASE_DB;
          w_db_nxt = '0;
        end else if (RPT_EN) begin
          w_rpt_nxt  = w_rpt_inc;
          w_done_nxt = r_rpt_done;
          // First pulse uses the hold delay, later ones
          // the repeat period; a pulse is dropped if o_t
          // is already high so pulses never merge.
          if (!r_rpt_done && r_rpt_cnt == HOLD_LAST) begin
            w_rpt_nxt  = '0;
            w_done_nxt = 1'b1;
            w_t_nxt    = !r_t;
          end else if (r_rpt_done &&
                       r_rpt_cnt == RPT_LAST) begin
            w_rpt_nxt = '0;
            w_t_nxt   = !r_t;
          end
        end
      end
      RELEASE_DB: begin
        if (!w_key_s) begin
          w_nxt    = PRESSED;
          w_db_nxt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_nxt    = IDLE;
          w_db_nxt = '0;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end
      default: begin
        w_nxt    = IDLE;
        w_db_nxt = '0;
      end
    endcase
  end

  assign o_t         = r_t;
  assign o_key_level = r_level;

endmodule
